dm_unit: RTL and testbench

DM_UNIT -- requirements
Module: dm_unit

---
 rtl/dm_unit.sv | 115 +++++++++++
 tb/tb_dm_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dm_unit.sv
// Data memory for the M stage: 4 KB little-endian word array, sb/sh/sw stores, sign/zero-extended loads.
// Optional macro DM_MISALIGN_TRAP_EN: flag misaligned accesses (exc_adel/exc_ades) and drop misaligned stores.
module dm_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic [1:0]  st_type,
  input  logic [2:0]  ld_type,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam int unsigned DEPTH = 1024;

  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;

  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LHU = 3'b010;
  localparam logic [2:0] LD_LB  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;

  logic [31:0] mem_reg [DEPTH];

  logic [9:0]  word_idx;
  logic [1:0]  byte_off;
  logic        half_sel;
  logic        is_sh;
  logic        is_sb;
  logic [3:0]  byte_en;
  logic [31:0] lane_data;
  logic        st_commit;
  logic [31:0] word_q;
  logic [7:0]  word_bytes [4];
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        unused_addr_hi;

  // Upper address bits simply alias onto the 4 KB array.
  assign unused_addr_hi = ^addr[31:12];

  assign word_idx = addr[11:2];
  assign byte_off = addr[1:0];
  assign half_sel = addr[1];
  assign is_sh    = (st_type == ST_SH);
  assign is_sb    = (st_type == ST_SB);

  // Per-lane enable and replicated store data; word stores (incl. 2'b11) touch every lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_en[gi] = is_sb ? (byte_off == 2'(gi)) :
                           is_sh ? (half_sel == ((gi >= 2) ? 1'b1 : 1'b0)) :
                                   1'b1;
      assign lane_data[8*gi +: 8] = is_sb ? wdata[7:0] :
                                    is_sh ? wdata[8*(gi % 2) +: 8] :
                                            wdata[8*gi +: 8];
      assign word_bytes[gi] = word_q[8*gi +: 8];
    end
  endgenerate

`ifdef DM_MISALIGN_TRAP_EN
  logic st_misalign;
  logic ld_misalign;

  assign st_misalign = (!is_sh && !is_sb && (addr[1:0] != 2'b00)) ||
                       (is_sh && addr[0]);
  assign ld_misalign = (((ld_type != LD_LH) && (ld_type != LD_LHU) &&
                         (ld_type != LD_LB) && (ld_type != LD_LBU)) && (addr[1:0] != 2'b00)) ||
                       (((ld_type == LD_LH) || (ld_type == LD_LHU)) && addr[0]);

  assign exc_ades = mem_write & st_misalign;
  assign exc_adel = ld_misalign;
`else
  assign exc_ades = 1'b0;
  assign exc_adel = 1'b0;
`endif

  // A trapped store must leave memory untouched.
  assign st_commit = mem_write & ~exc_ades;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (st_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          mem_reg[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
        end
      end
    end
  end

  // Asynchronous read: a same-cycle write is seen only after the clock edge.
  assign word_q  = mem_reg[word_idx];
  assign rd_byte = word_bytes[byte_off];
  assign rd_half = half_sel ? word_q[31:16] : word_q[15:0];

  always_comb begin
    rdata = word_q;
    case (ld_type)
      LD_LH:   rdata = {{16{rd_half[15]}}, rd_half};
      LD_LHU:  rdata = {16'h0000, rd_half};
      LD_LB:   rdata = {{24{rd_byte[7]}}, rd_byte};
      LD_LBU:  rdata = {24'h000000, rd_byte};
      default: rdata = word_q;
    endcase
  end

endmodule

// File: tb/tb_dm_unit.sv
// Directed self-checking bench for dm_unit; expectations follow DM_MISALIGN_TRAP_EN if defined.
module tb_dm_unit;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [1:0]  st_type;
  logic [2:0]  ld_type;
  logic [31:0] rdata;
  logic        exc_adel;
  logic        exc_ades;

  int checks = 0;
  int errors = 0;

`ifdef DM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  dm_unit dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .st_type   (st_type),
    .ld_type   (ld_type),
    .rdata     (rdata),
    .exc_adel  (exc_adel),
    .exc_ades  (exc_ades)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  // Present a store for one clock edge, confirming no store exception for aligned accesses.
  task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    @(negedge clk);
    addr = a; wdata = d; st_type = t; mem_write = 1'b1;
    #1;
    check({tag, "_ades"}, {31'b0, exc_ades}, 32'h0);
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [2:0] t, input logic [31:0] exp);
    addr = a; ld_type = t;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; mem_write = 1'b0; st_type = 2'b00; ld_type = 3'b000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Post-reset state
    #1;
    check("rst_adel", {31'b0, exc_adel}, 32'h0);
    check("rst_ades", {31'b0, exc_ades}, 32'h0);
    load("rst_lw_000", 32'h0,   3'b000, 32'h0);
    load("rst_lw_7fc", 32'h7FC, 3'b000, 32'h0);
    load("rst_lw_ffc", 32'hFFC, 3'b000, 32'h0);
    load("rst_lb_ffc", 32'hFFC, 3'b011, 32'h0);

    // Byte/half extraction from a full word
    store("sw10", 32'h10, 32'h12345678, 2'b00);
    load("lb_10",  32'h10, 3'b011, 32'h00000078);
    load("lb_13",  32'h13, 3'b011, 32'h00000012);
    load("lh_12",  32'h12, 3'b001, 32'h00001234);
    load("lbu_11", 32'h11, 3'b100, 32'h00000056);

    // Partial stores leave other bytes alone
    store("sw20", 32'h20, 32'h00000000, 2'b00);
    store("sb21", 32'h21, 32'h000000F0, 2'b10);
    store("sh22", 32'h22, 32'h00008001, 2'b01);
    load("lw_20",  32'h20, 3'b000, 32'h8001F000);
    load("lb_21",  32'h21, 3'b011, 32'hFFFFFFF0);
    load("lbu_21", 32'h21, 3'b100, 32'h000000F0);
    load("lhu_22", 32'h22, 3'b010, 32'h00008001);
    load("lh_22",  32'h22, 3'b001, 32'hFFFF8001);
    load("lh_20",  32'h20, 3'b001, 32'hFFFFF000);
    load("ld7_20", 32'h20, 3'b111, 32'h8001F000);

    // Type 2'b11 behaves as a word store
    store("st3_50", 32'h50, 32'hDEADBEEF, 2'b11);
    load("lw_50",  32'h50, 3'b000, 32'hDEADBEEF);

    // Address wrap modulo 4 KB
    store("sw1004", 32'h00001004, 32'hCAFEBABE, 2'b00);
    load("lw_wrap", 32'h00000004, 3'b000, 32'hCAFEBABE);

    // Read during write: old data this cycle, new data next
    store("sw40", 32'h40, 32'h22222222, 2'b00);
    @(negedge clk);
    addr = 32'h40; wdata = 32'h11111111; st_type = 2'b00; ld_type = 3'b000; mem_write = 1'b1;
    #1;
    check("rdw_old", rdata, 32'h22222222);
    @(negedge clk);
    mem_write = 1'b0;
    #1;
    check("rdw_new", rdata, 32'h11111111);

    // Misaligned word store and load
    @(negedge clk);
    addr = 32'h31; wdata = 32'hAAAAAAAA; st_type = 2'b00; mem_write = 1'b1;
    #1;
    check("mis_ades", {31'b0, exc_ades}, {31'b0, TRAP});
    @(negedge clk);
    mem_write = 1'b0;
    load("mis_lw_30", 32'h30, 3'b000, TRAP ? 32'h0 : 32'hAAAAAAAA);
    check("lw30_adel", {31'b0, exc_adel}, 32'h0);
    load("mis_lw_32", 32'h32, 3'b000, TRAP ? 32'h0 : 32'hAAAAAAAA);
    check("lw32_adel", {31'b0, exc_adel}, {31'b0, TRAP});
    load("mis_lhu_33", 32'h33, 3'b010, TRAP ? 32'h0 : 32'h0000AAAA);
    check("lhu33_adel", {31'b0, exc_adel}, {31'b0, TRAP});
    load("lb_33", 32'h33, 3'b011, TRAP ? 32'h0 : 32'hFFFFFFAA);
    check("lb33_adel", {31'b0, exc_adel}, 32'h0);

    // Misaligned halfword store
    @(negedge clk);
    addr = 32'h61; wdata = 32'h0000BEEF; st_type = 2'b01; mem_write = 1'b1;
    #1;
    check("mis_sh_ades", {31'b0, exc_ades}, {31'b0, TRAP});
    @(negedge clk);
    mem_write = 1'b0;
    load("mis_lw_60", 32'h60, 3'b000, TRAP ? 32'h0 : 32'h0000BEEF);

    // Reset wins over a simultaneous store and clears the whole array
    store("sw08", 32'h8, 32'h55555555, 2'b00);
    load("lw_08", 32'h8, 3'b000, 32'h55555555);
    @(negedge clk);
    rst = 1'b1; addr = 32'h8; wdata = 32'hFFFFFFFF; st_type = 2'b00; mem_write = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_write = 1'b0;
    load("rst_sw_08", 32'h8,  3'b000, 32'h0);
    load("rst_lw_10", 32'h10, 3'b000, 32'h0);
    load("rst_lhu_22", 32'h22, 3'b010, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
